div_unit: RTL and testbench

Multi-cycle divide/remainder execution unit for the RISC-V 3-stage CPU. It sits beside the single-cycle ALU in the EX stage and consumes the control-unit ALU opcodes for DIV/DIVU (4'b1110) and REM/REMU (4'b1111). It uses funct3[0] to choose signed or unsigned operation. It computes the result with a radix-2 restoring algorithm and stalls the pipeline until the result is ready.

---
 rtl/div_unit.sv | 148 ++++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divide/remainder unit for the EX stage.
// Holds the pipeline via stall_EX until the registered result is valid.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       aluop_EX,
   input  logic [2:0]       funct3_EX,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic             stall_EX
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic [CW-1:0]    cnt_r;
   logic             is_rem_r;
   logic             qsign_r;
   logic             rsign_r;

   logic             accept_s;
   logic             is_signed_s;
   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;
   logic             div0_s;
   logic             ovf_s;
   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] q_fix_s;
   logic [WIDTH-1:0] r_fix_s;
   logic             unused_s;

   function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign accept_s    = start & ~busy & (aluop_EX[3:1] == 3'b111);
   assign stall_EX    = accept_s | busy;
   assign is_signed_s = ~funct3_EX[0];
   assign a_neg_s     = is_signed_s & a[WIDTH-1];
   assign b_neg_s     = is_signed_s & b[WIDTH-1];
   assign a_mag_s     = a_neg_s ? neg2c(a) : a;
   assign b_mag_s     = b_neg_s ? neg2c(b) : b;
   assign div0_s      = (b == {WIDTH{1'b0}});
   assign ovf_s       = is_signed_s & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == {WIDTH{1'b1}});

   // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
   assign shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
   assign trial_s = shift_s - {1'b0, dvs_r};

   assign q_fix_s  = qsign_r ? neg2c(quo_r) : quo_r;
   assign r_fix_s  = rsign_r ? neg2c(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
   assign unused_s = &{1'b0, funct3_EX[2:1], rem_r[WIDTH]};

   // Divider sequencer with registered result, valid pulse and busy flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         rem_r        <= {(WIDTH+1){1'b0}};
         quo_r        <= {WIDTH{1'b0}};
         dvs_r        <= {WIDTH{1'b0}};
         cnt_r        <= {CW{1'b0}};
         is_rem_r     <= 1'b0;
         qsign_r      <= 1'b0;
         rsign_r      <= 1'b0;
         result       <= {WIDTH{1'b0}};
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  is_rem_r <= aluop_EX[0];
                  busy     <= 1'b1;
                  cnt_r    <= {CW{1'b0}};
                  dvs_r    <= b_mag_s;
                  if (div0_s) begin
                     quo_r   <= {WIDTH{1'b1}};
                     rem_r   <= {1'b0, a};
                     qsign_r <= 1'b0;
                     rsign_r <= 1'b0;
                     state_r <= FIX;
                  end else if (ovf_s) begin
                     quo_r   <= a;
                     rem_r   <= {(WIDTH+1){1'b0}};
                     qsign_r <= 1'b0;
                     rsign_r <= 1'b0;
                     state_r <= FIX;
                  end else begin
                     quo_r   <= a_mag_s;
                     rem_r   <= {(WIDTH+1){1'b0}};
                     qsign_r <= a_neg_s ^ b_neg_s;
                     rsign_r <= a_neg_s;
                     state_r <= CALC;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (!trial_s[WIDTH]) begin
                  rem_r <= trial_s;
                  quo_r <= {quo_r[WIDTH-2:0], 1'b1};
               end else begin
                  rem_r <= shift_s;
                  quo_r <= {quo_r[WIDTH-2:0], 1'b0};
               end
               if (cnt_r == CNT_LAST) begin
                  state_r <= FIX;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            FIX: begin
               result       <= is_rem_r ? r_fix_s : q_fix_s;
               result_valid <= 1'b1;
               busy         <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table-driven vectors with a result scoreboard
// plus hand-written ignored-request, back-to-back and mid-op reset sequences.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  aluop_EX = 4'b0000;
   logic [2:0]  funct3_EX = 3'b000;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] result;
   logic        result_valid;
   logic        busy;
   logic        stall_EX;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .aluop_EX(aluop_EX),
      .funct3_EX(funct3_EX), .a(a), .b(b), .result(result),
      .result_valid(result_valid), .busy(busy), .stall_EX(stall_EX)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] OP_Q = 4'b1110;
   localparam logic [3:0] OP_R = 4'b1111;
   localparam logic [2:0] F_S  = 3'b100;
   localparam logic [2:0] F_U  = 3'b101;

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;

   vec_t vecs[13];
   sb_t  sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   valid_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Scoreboard: every result_valid pulse pops and compares the oldest expectation.
   always @(negedge clk) begin
      if (!reset && result_valid === 1'b1) begin
         valid_count++;
         if (sb.size() == 0) begin
            chk("unexpected_valid", result, 32'hDEAD_BEEF);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk(e.name, result, e.exp);
         end
      end
   end

   // Called mid-cycle: presents an op, checks accept stall, holds it across the accept edge.
   task automatic accept_op(input logic [3:0] op, input logic [2:0] f3, input logic [31:0] ta,
                            input logic [31:0] tb, input logic [31:0] exp, input string name);
      sb_t e;
      start = 1'b1; aluop_EX = op; funct3_EX = f3; a = ta; b = tb;
      e.exp = exp; e.name = name;
      sb.push_back(e);
      #1;
      chk({name, "_accept_stall"}, {31'd0, stall_EX}, 32'd1);
      @(posedge clk);
      acc_cyc = cyc + 1;
      #1;
      start = 1'b0; a = $urandom; b = $urandom; funct3_EX = 3'($urandom_range(0, 7));
   endtask

   // Waits for result_valid (bounded), checks latency, busy/stall during and after.
   task automatic wait_done(input int lat, input string name);
      int busy_err = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            chk({name, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(lat));
            chk({name, "_busy_flags"}, 32'(busy_err), 32'd0);
            chk({name, "_valid_cycle_stall"}, {30'd0, busy, stall_EX}, 32'd0);
            return;
         end
         if (busy !== 1'b1 || stall_EX !== 1'b1) busy_err++;
      end
      chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int vc;
      vecs[0]  = '{OP_Q, F_U, 32'd100,        32'd7,          32'd14,         34, "divu_100_7"};
      vecs[1]  = '{OP_R, F_U, 32'd100,        32'd7,          32'd2,          34, "remu_100_7"};
      vecs[2]  = '{OP_Q, F_S, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, "div_m7_2"};
      vecs[3]  = '{OP_R, F_S, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, "rem_m7_2"};
      vecs[4]  = '{OP_R, F_S, 32'd7,          32'hFFFF_FFFE,  32'd1,          34, "rem_7_m2"};
      vecs[5]  = '{OP_Q, F_S, 32'd5,          32'd0,          32'hFFFF_FFFF,  2,  "div_by0"};
      vecs[6]  = '{OP_R, F_U, 32'd5,          32'd0,          32'd5,          2,  "remu_by0"};
      vecs[7]  = '{OP_Q, F_S, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2,  "div_ovf"};
      vecs[8]  = '{OP_R, F_S, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2,  "rem_ovf"};
      vecs[9]  = '{OP_Q, F_U, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, "divu_max_1"};
      vecs[10] = '{OP_Q, F_S, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, "div_m1_1"};
      vecs[11] = '{OP_Q, F_U, 32'd3,          32'd10,         32'd0,          34, "divu_3_10"};
      vecs[12] = '{OP_R, F_U, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, "remu_big"};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("reset_result", result, 32'd0);
      chk("reset_flags", {29'd0, result_valid, busy, stall_EX}, 32'd0);

      // Non-divide request while idle must not stall or start the unit.
      start = 1'b1; aluop_EX = 4'b0011; funct3_EX = F_U; a = 32'd9; b = 32'd3;
      #1;
      chk("idle_nondiv_stall", {31'd0, stall_EX}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("idle_nondiv_busy", {31'd0, busy}, 32'd0);

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         accept_op(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
         wait_done(vecs[i].lat, vecs[i].name);
      end

      // Requests while busy (valid divide and non-divide) are ignored.
      @(posedge clk); #1;
      vc = valid_count;
      accept_op(OP_Q, F_U, 32'd100, 32'd7, 32'd14, "busy_ignore");
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; aluop_EX = OP_Q; funct3_EX = F_U; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; aluop_EX = 4'b0011;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(34, "busy_ignore");
      repeat (40) @(posedge clk);
      #1;
      chk("busy_ignore_pulses", 32'(valid_count - vc), 32'd1);
      chk("busy_ignore_hold", result, 32'd14);

      // Back-to-back: new op presented during the result_valid cycle.
      @(posedge clk); #1;
      accept_op(OP_R, F_U, 32'd50, 32'd8, 32'd2, "b2b_first");
      wait_done(34, "b2b_first");
      accept_op(OP_Q, F_U, 32'd42, 32'd6, 32'd7, "b2b_second");
      wait_done(34, "b2b_second");

      // Reset mid-operation aborts without a valid pulse and clears result.
      @(posedge clk); #1;
      accept_op(OP_Q, F_U, 32'd100, 32'd7, 32'd14, "reset_abort");
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      sb.delete();
      chk("midreset_result", result, 32'd0);
      chk("midreset_flags", {29'd0, result_valid, busy, stall_EX}, 32'd0);
      vc = valid_count;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("midreset_no_valid", 32'(valid_count - vc), 32'd0);
      accept_op(OP_Q, F_U, 32'd42, 32'd6, 32'd7, "after_reset");
      wait_done(34, "after_reset");

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
